// File: rtl/enc4x2_neg_buf_if.sv
// Handshake bundle for enc4x2_neg_buf: sample strobe and active-low lines in,
// queued {err, code} entries out over valid/ready with full/overflow status.
interface enc4x2_neg_buf_if;
  logic       en;
  logic [3:0] d_n;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_code;
  logic       out_err;
  logic       full;
  logic       ovf;

  modport master (
    output en, d_n, out_ready,
    input  out_valid, out_code, out_err, full, ovf
  );

  modport slave (
    input  en, d_n, out_ready,
    output out_valid, out_code, out_err, full, ovf
  );
endinterface

// File: rtl/enc4x2_neg_buf.sv
// Registered 4-to-2 encoder for active-low one-hot lines feeding a DEPTH-entry FIFO.
// Optional macro ENC_CHANGE_ONLY_EN suppresses pushes that repeat the last pushed entry.
module enc4x2_neg_buf #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  enc4x2_neg_buf_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Returns {err, code}: highest asserted index, err unless exactly one line is low.
  function automatic logic [2:0] enc_f(input logic [3:0] d_n);
    logic [3:0] a;
    logic [1:0] code;
    logic       err;
    a = ~d_n;
    if (a[3]) begin
      code = 2'd3;
    end else if (a[2]) begin
      code = 2'd2;
    end else if (a[1]) begin
      code = 2'd1;
    end else begin
      code = 2'd0;
    end
    case (a)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: err = 1'b0;
      default:                            err = 1'b1;
    endcase
    return {err, code};
  endfunction

  logic [2:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic [2:0]    ent_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          req_s;
  logic          push_s;
  logic          drop_s;

`ifdef ENC_CHANGE_ONLY_EN
  logic [2:0] last_ent_r;
  logic       last_vld_r;
`endif

  always_comb begin
    ent_s   = enc_f(bus.d_n);
    empty_s = (count_r == {CW{1'b0}});
    full_s  = (count_r == CW'(DEPTH));
    pop_s   = !empty_s && bus.out_ready;
`ifdef ENC_CHANGE_ONLY_EN
    req_s   = bus.en && !(last_vld_r && (ent_s == last_ent_r));
`else
    req_s   = bus.en;
`endif
    // A full FIFO still takes a write when the head leaves on the same edge.
    push_s  = req_s && (!full_s || pop_s);
    drop_s  = req_s && full_s && !pop_s;
  end

  // Pointer, occupancy and overflow state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

`ifdef ENC_CHANGE_ONLY_EN
  // Last pushed entry; invalid after reset so the first strobe always pushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ent_r <= 3'b000;
      last_vld_r <= 1'b0;
    end else if (push_s) begin
      last_ent_r <= ent_s;
      last_vld_r <= 1'b1;
    end
  end
`endif

  // Storage needs no reset: entries are only visible through count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ent_s;
    end
  end

  assign bus.out_valid = !empty_s;
  assign bus.full      = full_s;
  assign bus.ovf       = ovf_r;
  assign bus.out_code  = empty_s ? 2'b00 : mem_r[rd_ptr_r][1:0];
  assign bus.out_err   = empty_s ? 1'b0  : mem_r[rd_ptr_r][2];
endmodule

// File: tb/tb_enc4x2_neg_buf.sv
// Directed and random stimulus for enc4x2_neg_buf against a queue-based reference model.
module tb_enc4x2_neg_buf;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [2:0] q [$];
  logic       ovf_m;
  logic [2:0] last_m;
  logic       last_v_m;

  enc4x2_neg_buf_if bus ();

  enc4x2_neg_buf #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] ref_enc(input logic [3:0] d_n);
    logic [3:0] a;
    int n;
    int hi;
    a  = ~d_n;
    n  = $countones(a);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) hi = i;
    end
    return {(n != 1), 2'(hi)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string when);
    logic [2:0] head;
    head = (q.size() != 0) ? q[0] : 3'b000;
    check({when, " out_valid"}, {7'd0, bus.out_valid}, {7'd0, (q.size() != 0)});
    check({when, " full"},      {7'd0, bus.full},      {7'd0, (q.size() == DEPTH)});
    check({when, " ovf"},       {7'd0, bus.ovf},       {7'd0, ovf_m});
    check({when, " out_code"},  {6'd0, bus.out_code},  {6'd0, head[1:0]});
    check({when, " out_err"},   {7'd0, bus.out_err},   {7'd0, head[2]});
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m    = 1'b0;
    last_v_m = 1'b0;
    last_m   = 3'b000;
  endtask

  // One clock: drive inputs, confirm outputs ignore them pre-edge, advance model and compare.
  task automatic cycle(input logic e, input logic [3:0] d, input logic r, input logic rs);
    logic [2:0] ent;
    logic is_full, pop, req, push, drop;
    bus.en        = e;
    bus.d_n       = d;
    bus.out_ready = r;
    rst_n         = rs;
    #1;
    check_all("pre");
    ent     = ref_enc(d);
    is_full = (q.size() == DEPTH);
    pop     = (q.size() != 0) && r;
`ifdef ENC_CHANGE_ONLY_EN
    req     = e && !(last_v_m && ent == last_m);
`else
    req     = e;
`endif
    push    = req && (!is_full || pop);
    drop    = req && is_full && !pop;
    @(posedge clk);
    if (!rs) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(ent);
        last_m   = ent;
        last_v_m = 1'b1;
      end
      if (drop) ovf_m = 1'b1;
    end
    #1;
    check_all("post");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    bus.en        = 1'b0;
    bus.d_n       = 4'b1111;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    // One-hot sweep with consumer ready, then drain.
    cycle(1'b1, 4'b1110, 1'b1, 1'b1);
    cycle(1'b1, 4'b1101, 1'b1, 1'b1);
    cycle(1'b1, 4'b1011, 1'b1, 1'b1);
    cycle(1'b1, 4'b0111, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 1'b1, 1'b1);

    // One-hot violations: none asserted, then two asserted.
    cycle(1'b1, 4'b1111, 1'b0, 1'b1);
    cycle(1'b1, 4'b0101, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 4'b1010, 1'b1, 1'b1);

    // Overflow: five strobes with consumer stalled, then drain.
    cycle(1'b1, 4'b1110, 1'b0, 1'b1);
    cycle(1'b1, 4'b1101, 1'b0, 1'b1);
    cycle(1'b1, 4'b1011, 1'b0, 1'b1);
    cycle(1'b1, 4'b0111, 1'b0, 1'b1);
    cycle(1'b1, 4'b1110, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 4'b0000, 1'b1, 1'b1);

    // Clear ovf, then full FIFO with simultaneous push and pop.
    cycle(1'b0, 4'b1111, 1'b0, 1'b0);
    cycle(1'b1, 4'b0111, 1'b0, 1'b1);
    cycle(1'b1, 4'b1011, 1'b0, 1'b1);
    cycle(1'b1, 4'b1101, 1'b0, 1'b1);
    cycle(1'b1, 4'b1110, 1'b0, 1'b1);
    cycle(1'b1, 4'b0000, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 4'b0000, 1'b1, 1'b1);

    // Reset mid-stream with a push requested on the reset edge.
    cycle(1'b1, 4'b1110, 1'b0, 1'b1);
    cycle(1'b1, 4'b1101, 1'b0, 1'b1);
    cycle(1'b1, 4'b1011, 1'b0, 1'b1);
    cycle(1'b1, 4'b0111, 1'b1, 1'b0);
    cycle(1'b1, 4'b1101, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 1'b1, 1'b1);

    // Repeated identical strobes (collapsed when change-only mode is built in).
    cycle(1'b1, 4'b1110, 1'b0, 1'b1);
    cycle(1'b1, 4'b1110, 1'b0, 1'b1);
    cycle(1'b1, 4'b1110, 1'b0, 1'b1);
    cycle(1'b1, 4'b1101, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 4'b0000, 1'b1, 1'b1);

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 63) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/enc4x2_neg_buf.md
# enc4x2_neg_buf

Registered 4-to-2 encoder for active-low one-hot lines, the return path for our 2x4 negative-output, positive-enable decoder: it takes the four decoder lines back to a 2-bit code. Each strobed sample is encoded, checked for a one-hot violation, and queued in a small FIFO. The FIFO drains over a valid/ready handshake, so the encoder can sit between a decoder-driven structure and a slower checker or logger.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  positive sample strobe; push request when 1
- d_n  in  4  active-low decoder lines; d_n[i]=0 means line i asserted
- out_ready  in  1  consumer accepts head entry
- out_valid  out  1  FIFO non-empty
- out_code  out  2  encoded index of head entry
- out_err  out  1  head entry was not exactly one-hot
- full  out  1  FIFO holds DEPTH entries
- ovf  out  1  sticky: a push was dropped because FIFO was full

## Operation
- Encode, combinational on d_n:
  - Let a = ~d_n, the asserted lines.
  - Exactly one bit of a set: code = its index, err = 0.
  - No bits set: code = 00, err = 1.
  - Two or more bits set: code = highest set index, err = 1.
- Push occurs on a clock edge when en=1 and the FIFO accepts a write.
  - The FIFO accepts when full=0, or when full=1 and a pop occurs on the same edge.
  - A push writes {err, code} at the write pointer.
- Pop occurs on a clock edge when out_valid=1 and out_ready=1. It advances the read pointer.
- Occupancy count: 0..DEPTH, width clog2(DEPTH)+1.
  - Push only: +1. Pop only: -1. Both or neither: unchanged.
- Pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Dropped push: en=1, full=1, and no pop on that edge.
  - The entry is discarded.
  - ovf is set to 1 and stays 1 until reset.
- out_code and out_err show the head entry while out_valid=1. Both are 0 when the FIFO is empty.
- en=0 never pushes, whatever d_n holds. This mirrors the decoder's enable.

## Timing
- Reset values: out_valid=0, out_code=00, out_err=0, full=0, ovf=0. Pointers and count are 0.
- Latency: with an empty FIFO, a push on edge N gives out_valid=1 after edge N.
  - The entry is visible in the cycle after the strobe.
  - There is no same-cycle bypass.
- out_valid, full, out_code and out_err are registered or decoded from registered state only. No combinational path from en, d_n or out_ready to any output.
- Once out_valid=1, the head entry stays stable until it is popped.
- Simultaneous push and pop:
  - Empty FIFO: pop is impossible, so only the push happens.
  - Full FIFO: both happen, full stays 1, ovf is unchanged.
- Reset asserted mid-operation (rst_n=0 at an edge):
  - All contents are discarded.
  - Outputs take their reset values at that edge, overriding any same-edge push or pop.
- d_n is sampled only at edges where en=1. Between strobes it may change freely.

## Configuration
- ENC_CHANGE_ONLY_EN
  - Defined: add a register last_ent holding the last pushed {err, code}.
    - A push with en=1 is suppressed when the new {err, code} equals last_ent.
    - A suppressed push counts neither as a write nor as a drop.
    - last_ent is invalid after reset, so the first strobe always pushes.
  - Undefined: every en=1 edge pushes or drops as described in Operation. No last_ent register.

## Test plan
- One-hot sweep: en=1 for 4 cycles with d_n=1110, 1101, 1011, 0111, out_ready=1.
  - Pops in order give codes 00, 01, 10, 11, each with err=0.
  - out_valid rises 1 cycle after the first strobe.
- Violations: push d_n=1111, then d_n=0101.
  - Required: {err=1, code=00}, then {err=1, code=11}.
- Overflow: out_ready=0, 5 strobes, DEPTH=4.
  - full=1 after the 4th strobe. ovf=1 after the 5th.
  - Draining yields exactly the first 4 entries in order.
- Full plus simultaneous pop: FIFO full, en=1 and out_ready=1 on the same edge.
  - full stays 1, ovf stays 0.
  - The new entry appears as the last of the next 4 pops.
- Reset mid-stream: 3 entries queued, then rst_n=0 for one edge.
  - out_valid=0, full=0, ovf=0, out_code=00, out_err=0 on the following cycle.
  - A strobe on the next edge gives out_valid=1 one cycle later.
- ENC_CHANGE_ONLY_EN defined: strobe d_n=1110 three times, then 1101.
  - Exactly 2 entries are queued: codes 00 then 01.
